edm_gap_state_detector: RTL and testbench
=========================================

Name: edm_gap_state_detector

Overview:
- Sits directly downstream of the sample-to-real-value conversion stage.
- Consumes the signed per-sample gap current (A) and gap voltage (V).
- Averages each quantity over fixed windows, classifies each window's gap condition (open / spark / short / idle), and debounces the classification into a stable gap state.
- Provides that state, the window averages and per-state window statistics to the pulse generator and servo control logic.

Parameters:
- AVG_LOG2, 3: log2 of the window length; N = 2^AVG_LOG2 valid samples per window.
- V_OPEN, 60: avg_voltage >= V_OPEN classifies the window as OPEN (V, signed).
- V_SHORT, 10: avg_voltage <= V_SHORT with high current classifies the window as SHORT (V, signed).
- I_SPARK, 5: avg_current >= I_SPARK counts as discharge current (A, signed).
- DEBOUNCE, 4: number of consecutive identical raw classes required to change gap_state (1..15).
- CNT_W, 16: width of the statistics counters.

Ports:
- ad_clk  in  1  sample clock; all logic is in this single domain.
- rst_n  in  1  synchronous, active-low reset.
- sample_valid  in  1  qualifies sample_current and sample_voltage this cycle.
- sample_current  in  16  signed gap current, A.
- sample_voltage  in  16  signed gap voltage, V.
- clear_stats  in  1  synchronous clear of the statistics counters.
- avg_current  out  16  signed window-average current.
- avg_voltage  out  16  signed window-average voltage.
- avg_valid  out  1  one-cycle pulse marking new averages.
- gap_state  out  2  debounced state: 00 OPEN, 01 SPARK, 10 SHORT, 11 IDLE.
- state_change  out  1  one-cycle pulse when gap_state changes.
- open_cnt, spark_cnt, short_cnt, idle_cnt  out  CNT_W each  windows spent in each state.

Behaviour:
- Reset (rst_n low at a clock edge):
  - All outputs and counters are 0; gap_state is OPEN.
  - Accumulators, sample index, candidate class (OPEN) and debounce count are cleared.
  - Reset mid-window discards the partial window.
- Window averager:
  - Accumulator width is 16+AVG_LOG2, signed; sample index k runs 0..N-1.
  - On sample_valid with k<N-1: sum += sample, k++.
  - On sample_valid with k==N-1: avg <= (sum+sample) >>> AVG_LOG2 (arithmetic shift, floor toward -inf); sum <= 0; k <= 0; avg_valid = 1 on the next cycle.
  - Cycles with sample_valid low hold all averager state.
- Latency:
  - Last sample of a window accepted at edge t.
  - avg_* and avg_valid visible after edge t+1.
  - gap_state, state_change and counters updated at edge t+2.
- Raw class (combinational on the avg registers), evaluated in priority order:
  - avg_voltage >= V_OPEN -> OPEN.
  - else avg_current >= I_SPARK and avg_voltage <= V_SHORT -> SHORT.
  - else avg_current >= I_SPARK -> SPARK.
  - else IDLE.
- Debounce FSM; the states are the four gap_state values. On each avg_valid:
  - raw == gap_state: candidate <= raw, dcount <= 0.
  - raw != candidate: candidate <= raw, dcount <= 1; if DEBOUNCE==1, switch immediately.
  - raw == candidate != gap_state: dcount++. When dcount reaches DEBOUNCE, gap_state <= raw, dcount <= 0, and state_change pulses one cycle.
  - Without avg_valid, the FSM holds.
- Statistics:
  - On each FSM update, the counter for the post-update gap_state increments.
  - Counters saturate at all-ones.
  - clear_stats zeroes all four counters. If clear and increment coincide, the clear wins and the result is 0.

Decomposition:
- Shared package edm_gap_pkg holds the gap_state encoding constants and the default threshold values.
- One natural sub-module, window_averager (generic accumulate-and-dump, width and AVG_LOG2 parameters), instantiated twice: once for current, once for voltage.
- Classifier, debounce FSM and counters stay in the top module.

Test Plan:
- Reset with sample_valid=1 and random inputs -> all outputs 0, gap_state=00, no avg_valid pulse while rst_n is low.
- 8 samples, current 0..7 and voltage -8 each, with sample_valid gaps inserted -> one avg_valid pulse one cycle after the 8th sample; avg_current=3, avg_voltage=-8.
- Current seven -1 and one -2 (sum -9) -> avg_current=-2 (floor, not truncation toward 0).
- Debounce:
  - 3 windows at V=25, I=20, then 1 window at V=80 -> gap_state stays OPEN and there is no state_change.
  - Then 4 windows at V=25, I=20 -> SPARK at edge t+2 of the 4th window, state_change pulses exactly once, spark_cnt=1.
- 4 windows at V=5, I=30 -> SHORT; then 4 windows at V=2, I=0 -> IDLE; then 4 windows at V=70 -> OPEN. Each transition produces exactly one state_change.
- CNT_W=4 override, 20 OPEN windows -> open_cnt=15 (saturated). clear_stats asserted on an FSM-update cycle -> all counters 0 on the following cycle.

Source files
------------

// File: rtl/edm_gap_state_detector_pkg.sv
// Shared gap-state encoding and default thresholds for the EDM gap state detector.
package edm_gap_pkg;

    typedef enum logic [1:0] {
        GAP_OPEN  = 2'b00,
        GAP_SPARK = 2'b01,
        GAP_SHORT = 2'b10,
        GAP_IDLE  = 2'b11
    } gap_state_t;

    localparam int SAMPLE_W     = 16;
    localparam int DEF_AVG_LOG2 = 3;
    localparam int DEF_V_OPEN   = 60;
    localparam int DEF_V_SHORT  = 10;
    localparam int DEF_I_SPARK  = 5;
    localparam int DEF_DEBOUNCE = 4;
    localparam int DEF_CNT_W    = 16;

endpackage

// File: rtl/edm_gap_state_detector_if.sv
// Sample input, averages, gap state and statistics bundle of the gap state detector.
interface edm_gap_state_detector_if
    import edm_gap_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic                       sample_valid;
    logic signed [SAMPLE_W-1:0] sample_current;
    logic signed [SAMPLE_W-1:0] sample_voltage;
    logic                       clear_stats;
    logic signed [SAMPLE_W-1:0] avg_current;
    logic signed [SAMPLE_W-1:0] avg_voltage;
    logic                       avg_valid;
    gap_state_t                 gap_state;
    logic                       state_change;
    logic [CNT_W-1:0]           open_cnt;
    logic [CNT_W-1:0]           spark_cnt;
    logic [CNT_W-1:0]           short_cnt;
    logic [CNT_W-1:0]           idle_cnt;

    modport master (
        output sample_valid, sample_current, sample_voltage, clear_stats,
        input  avg_current, avg_voltage, avg_valid, gap_state, state_change,
               open_cnt, spark_cnt, short_cnt, idle_cnt
    );

    modport slave (
        input  sample_valid, sample_current, sample_voltage, clear_stats,
        output avg_current, avg_voltage, avg_valid, gap_state, state_change,
               open_cnt, spark_cnt, short_cnt, idle_cnt
    );
endinterface

// File: rtl/edm_gap_state_detector_window_averager.sv
// Accumulate-and-dump averager over 2^AVG_LOG2 valid samples, floor-rounded.
module window_averager #(
    parameter int W        = 16,
    parameter int AVG_LOG2 = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic signed [W-1:0] in_data,
    output logic signed [W-1:0] avg,
    output logic                avg_valid
);
    localparam int AW = W + AVG_LOG2;
    localparam int KW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int N  = 1 << AVG_LOG2;

    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] sum_next;
    logic signed [W-1:0]  pend;
    logic [KW-1:0]        k;
    logic                 last;
    logic [1:0]           vld_pipe;

    assign sum_next  = acc + AW'(in_data);
    assign last      = (k == KW'(N - 1));
    assign avg_valid = vld_pipe[1];

    // The finished average is staged once so it lands one edge after the last sample.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc      <= '0;
            k        <= '0;
            pend     <= '0;
            avg      <= '0;
            vld_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[0], in_valid && last};
            if (in_valid) begin
                if (last) begin
                    pend <= W'(sum_next >>> AVG_LOG2);
                    acc  <= '0;
                    k    <= '0;
                end else begin
                    acc  <= sum_next;
                    k    <= k + 1'b1;
                end
            end
            if (vld_pipe[0])
                avg <= pend;
        end
    end
endmodule

// File: rtl/edm_gap_state_detector.sv
// Window-averages gap current/voltage, classifies each window and debounces it into a gap state.
module edm_gap_state_detector
    import edm_gap_pkg::*;
#(
    parameter int AVG_LOG2 = DEF_AVG_LOG2,
    parameter int V_OPEN   = DEF_V_OPEN,
    parameter int V_SHORT  = DEF_V_SHORT,
    parameter int I_SPARK  = DEF_I_SPARK,
    parameter int DEBOUNCE = DEF_DEBOUNCE,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                      ad_clk,
    input  logic                      rst_n,
    edm_gap_state_detector_if.slave   bus
);
    logic signed [SAMPLE_W-1:0] avg_i;
    logic signed [SAMPLE_W-1:0] avg_v;
    logic                       vld_i;
    logic                       vld_v;

    window_averager #(.W(SAMPLE_W), .AVG_LOG2(AVG_LOG2)) u_avg_i (
        .clk(ad_clk), .rst_n(rst_n), .in_valid(bus.sample_valid),
        .in_data(bus.sample_current), .avg(avg_i), .avg_valid(vld_i)
    );

    window_averager #(.W(SAMPLE_W), .AVG_LOG2(AVG_LOG2)) u_avg_v (
        .clk(ad_clk), .rst_n(rst_n), .in_valid(bus.sample_valid),
        .in_data(bus.sample_voltage), .avg(avg_v), .avg_valid(vld_v)
    );

    gap_state_t       raw;
    gap_state_t       gap_state;
    gap_state_t       cand;
    gap_state_t       nxt_state;
    gap_state_t       nxt_cand;
    logic [3:0]       dcount;
    logic [3:0]       nxt_dcount;
    logic             nxt_change;
    logic             state_change;
    logic [CNT_W-1:0] cnt [4];

    always_comb begin
        if (avg_v >= V_OPEN)
            raw = GAP_OPEN;
        else if (avg_i >= I_SPARK && avg_v <= V_SHORT)
            raw = GAP_SHORT;
        else if (avg_i >= I_SPARK)
            raw = GAP_SPARK;
        else
            raw = GAP_IDLE;
    end

    always_comb begin
        nxt_state  = gap_state;
        nxt_cand   = cand;
        nxt_dcount = dcount;
        nxt_change = 1'b0;
        if (raw == gap_state) begin
            nxt_cand   = raw;
            nxt_dcount = '0;
        end else if (raw != cand) begin
            nxt_cand = raw;
            if (DEBOUNCE == 1) begin
                nxt_state  = raw;
                nxt_dcount = '0;
                nxt_change = 1'b1;
            end else begin
                nxt_dcount = 4'd1;
            end
        end else if (dcount + 4'd1 == 4'(DEBOUNCE)) begin
            nxt_state  = raw;
            nxt_dcount = '0;
            nxt_change = 1'b1;
        end else begin
            nxt_dcount = dcount + 4'd1;
        end
    end

    // FSM and statistics advance only on a fresh window; clear beats a coincident increment.
    always_ff @(posedge ad_clk) begin
        if (!rst_n) begin
            gap_state    <= GAP_OPEN;
            cand         <= GAP_OPEN;
            dcount       <= '0;
            state_change <= 1'b0;
            for (int s = 0; s < 4; s++) cnt[s] <= '0;
        end else begin
            state_change <= 1'b0;
            if (vld_i) begin
                gap_state    <= nxt_state;
                cand         <= nxt_cand;
                dcount       <= nxt_dcount;
                state_change <= nxt_change;
            end
            if (bus.clear_stats) begin
                for (int s = 0; s < 4; s++) cnt[s] <= '0;
            end else if (vld_i && cnt[nxt_state] != '1) begin
                cnt[nxt_state] <= cnt[nxt_state] + 1'b1;
            end
        end
    end

    assign bus.avg_current  = avg_i;
    assign bus.avg_voltage  = avg_v;
    assign bus.avg_valid    = vld_i & vld_v;
    assign bus.gap_state    = gap_state;
    assign bus.state_change = state_change;
    assign bus.open_cnt     = cnt[GAP_OPEN];
    assign bus.spark_cnt    = cnt[GAP_SPARK];
    assign bus.short_cnt    = cnt[GAP_SHORT];
    assign bus.idle_cnt     = cnt[GAP_IDLE];
endmodule

// File: tb/tb_edm_gap_state_detector.sv
// Directed, table-driven bench for the gap state detector (default and 4-bit-counter builds).
module tb_edm_gap_state_detector;
    import edm_gap_pkg::*;

    logic ad_clk = 1'b0;
    logic rst_n  = 1'b0;
    always #5 ad_clk = ~ad_clk;

    edm_gap_state_detector_if #(.CNT_W(16)) bus ();
    edm_gap_state_detector_if #(.CNT_W(4))  bus4 ();

    edm_gap_state_detector #(.CNT_W(16)) dut (.ad_clk(ad_clk), .rst_n(rst_n), .bus(bus));
    edm_gap_state_detector #(.CNT_W(4))  dut4 (.ad_clk(ad_clk), .rst_n(rst_n), .bus(bus4));

    typedef struct {
        logic signed [15:0] cur;
        logic signed [15:0] volt;
        gap_state_t         st;
        int                 chg;
    } vec_t;

    vec_t vec [20];
    int total = 0;
    int bad   = 0;
    logic signed [15:0] wc [8];
    logic signed [15:0] wv [8];
    int early;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ad_clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic signed [15:0] c, input logic signed [15:0] u);
        bus.sample_valid    = v;  bus4.sample_valid    = v;
        bus.sample_current  = c;  bus4.sample_current  = c;
        bus.sample_voltage  = u;  bus4.sample_voltage  = u;
    endtask

    task automatic set_clear(input logic c);
        bus.clear_stats = c;
        bus4.clear_stats = c;
    endtask

    task automatic do_reset(input bit check);
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 16'($urandom), 16'($urandom));
            tick();
            if (check) begin
                chk("rst_avg_valid", int'(bus.avg_valid), 0);
                chk("rst_state", int'(bus.gap_state), int'(GAP_OPEN));
            end
        end
        if (check) begin
            chk("rst_avg", int'(bus.avg_current) | int'(bus.avg_voltage), 0);
            chk("rst_change", int'(bus.state_change), 0);
            chk("rst_cnt", int'(bus.open_cnt | bus.spark_cnt | bus.short_cnt | bus.idle_cnt), 0);
        end
        drive(1'b0, 16'sd0, 16'sd0);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic feed_window(input bit gaps);
        early = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, wc[i], wv[i]);
            tick();
            early += int'(bus.avg_valid);
            if (gaps && (i % 2 == 0)) begin
                drive(1'b0, 16'sh7fff, 16'sh7fff);
                tick();
                early += int'(bus.avg_valid);
            end
        end
        drive(1'b0, 16'sd0, 16'sd0);
    endtask

    task automatic post_window(input string name, input int ei, input int ev,
                               input gap_state_t est, input int echg);
        int ch;
        tick();
        chk({name, "_avg_valid"}, int'(bus.avg_valid), 1);
        chk({name, "_avg_i"}, int'(bus.avg_current), ei);
        chk({name, "_avg_v"}, int'(bus.avg_voltage), ev);
        ch = int'(bus.state_change);
        tick();
        ch += int'(bus.state_change);
        chk({name, "_state"}, int'(bus.gap_state), int'(est));
        tick();
        ch += int'(bus.state_change);
        chk({name, "_changes"}, ch, echg);
    endtask

    task automatic const_window(input logic signed [15:0] c, input logic signed [15:0] u);
        for (int i = 0; i < 8; i++) begin wc[i] = c; wv[i] = u; end
        feed_window(1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 20; i++) begin
            if (i < 3)       vec[i] = '{16'sd20, 16'sd25, GAP_OPEN, 0};
            else if (i == 3) vec[i] = '{16'sd20, 16'sd80, GAP_OPEN, 0};
            else if (i < 8)  vec[i] = '{16'sd20, 16'sd25, (i == 7) ? GAP_SPARK : GAP_OPEN, (i == 7) ? 1 : 0};
            else if (i < 12) vec[i] = '{16'sd30, 16'sd5,  (i == 11) ? GAP_SHORT : GAP_SPARK, (i == 11) ? 1 : 0};
            else if (i < 16) vec[i] = '{16'sd0,  16'sd2,  (i == 15) ? GAP_IDLE : GAP_SHORT, (i == 15) ? 1 : 0};
            else             vec[i] = '{16'sd0,  16'sd70, (i == 19) ? GAP_OPEN : GAP_IDLE, (i == 19) ? 1 : 0};
        end
        set_clear(1'b0);
        drive(1'b0, 16'sd0, 16'sd0);
        do_reset(1'b1);

        // Partial window is abandoned by a reset, so the next window starts clean.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'sd1000, 16'sd1000);
            tick();
        end
        do_reset(1'b0);

        for (int i = 0; i < 8; i++) begin wc[i] = 16'(i); wv[i] = -16'sd8; end
        feed_window(1'b1);
        chk("gap_early_valid", early, 0);
        post_window("gap_avg", 3, -8, GAP_OPEN, 0);

        for (int i = 0; i < 8; i++) begin wc[i] = -16'sd1; wv[i] = 16'sd100; end
        wc[7] = -16'sd2;
        feed_window(1'b0);
        post_window("floor", -2, 100, GAP_OPEN, 0);

        do_reset(1'b0);
        for (int i = 0; i < 20; i++) begin
            const_window(vec[i].cur, vec[i].volt);
            post_window($sformatf("vec%0d", i), int'(vec[i].cur), int'(vec[i].volt), vec[i].st, vec[i].chg);
            if (i == 7) begin
                chk("spark_cnt_after_switch", int'(bus.spark_cnt), 1);
                chk("open_cnt_after_switch", int'(bus.open_cnt), 7);
            end
        end
        chk("tbl_open", int'(bus.open_cnt), 8);
        chk("tbl_spark", int'(bus.spark_cnt), 4);
        chk("tbl_short", int'(bus.short_cnt), 4);
        chk("tbl_idle", int'(bus.idle_cnt), 4);
        chk("tbl_short_w4", int'(bus4.short_cnt), 4);

        do_reset(1'b0);
        for (int i = 0; i < 20; i++) begin
            const_window(16'sd0, 16'sd70);
            tick(); tick(); tick();
        end
        chk("sat_open_w4", int'(bus4.open_cnt), 15);
        chk("sat_open_w16", int'(bus.open_cnt), 20);
        chk("sat_state", int'(bus.gap_state), int'(GAP_OPEN));

        // Clear lands on the same edge as an FSM update.
        const_window(16'sd0, 16'sd70);
        tick();
        chk("clr_avg_valid", int'(bus.avg_valid), 1);
        set_clear(1'b1);
        tick();
        set_clear(1'b0);
        chk("clr_w16", int'(bus.open_cnt | bus.spark_cnt | bus.short_cnt | bus.idle_cnt), 0);
        chk("clr_w4", int'(bus4.open_cnt | bus4.spark_cnt | bus4.short_cnt | bus4.idle_cnt), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
